lb_pxl_win_cnt: RTL and testbench

Parametrised line-buffer fill and window counter for the convolution front end. It tracks channel, column and row position of a raster pixel stream, with channel innermost. It reports when the line buffer holds enough rows (fill), when each K×K window is complete, and when a frame ends. It supports single-shot or continuous-frame operation. It sits between the pixel source and the line buffer / window-extraction logic of each layer and generalises the single-output fill counter.

---
 rtl/lb_cnt_pkg.sv | 14 +
 rtl/lb_wrap_cnt.sv | 29 ++
 rtl/lb_pxl_win_cnt.sv | 121 ++++++++++++
 tb/tb_lb_pxl_win_cnt.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lb_cnt_pkg.sv
// Shared state encoding and frame-mode constants for the line-buffer fill/window counter.
package lb_cnt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM,
    DONE
  } cnt_state_t;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_CONT   = 1'b1;

endpackage

// File: rtl/lb_wrap_cnt.sv
// Modulus-MOD counter: value advances on en and returns to 0 after MOD-1.
// wrap_o is combinational (same cycle as the wrapping beat) so counters can be chained.
module lb_wrap_cnt #(
  parameter int MOD = 2,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] value_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  assign wrap_o = en && (value_o == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_o <= '0;
    end else if (clr) begin
      value_o <= '0;
    end else if (en) begin
      value_o <= wrap_o ? '0 : value_o + W'(1);
    end
  end

endmodule

// File: rtl/lb_pxl_win_cnt.sv
// Channel/column/row position tracker for a raster pixel stream with fill, window, line and frame events.
// Position and event outputs are registered (1 cycle after the accepted beat); cnt_en = 0 simply holds everything.
module lb_pxl_win_cnt
  import lb_cnt_pkg::*;
#(
  parameter int COLS     = 8,
  parameter int ROWS     = 4,
  parameter int CHANNELS = 1,
  parameter int KERNEL   = 3,
  localparam int COL_W   = $clog2(COLS),
  localparam int ROW_W   = $clog2(ROWS),
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             cnt_clk,
  input  logic             cnt_rst_b,
  input  logic             cnt_en,
  input  logic             cnt_clr,
  input  logic             cnt_mode_i,
  output logic [CH_W-1:0]  cnt_ch_o,
  output logic [COL_W-1:0] cnt_col_o,
  output logic [ROW_W-1:0] cnt_row_o,
  output logic             cnt_fill_done_o,
  output logic             cnt_win_vld_o,
  output logic             cnt_line_end_o,
  output logic             cnt_frame_done_o,
  output logic             cnt_done_o
);

  cnt_state_t state;
  logic       mode_q;
  logic       adv;
  logic       ch_wrap;
  logic       col_wrap;
  logic       row_wrap;
  logic       win_evt;
  logic       fill_evt;

  // DONE ignores beats; a clear drops the coincident beat.
  assign adv = cnt_en && !cnt_clr && (state != DONE);

  lb_wrap_cnt #(.MOD(CHANNELS), .W(CH_W)) u_ch_cnt (
    .clk     (cnt_clk),
    .rst_n   (cnt_rst_b),
    .en      (adv),
    .clr     (cnt_clr),
    .value_o (cnt_ch_o),
    .wrap_o  (ch_wrap)
  );

  lb_wrap_cnt #(.MOD(COLS), .W(COL_W)) u_col_cnt (
    .clk     (cnt_clk),
    .rst_n   (cnt_rst_b),
    .en      (ch_wrap),
    .clr     (cnt_clr),
    .value_o (cnt_col_o),
    .wrap_o  (col_wrap)
  );

  lb_wrap_cnt #(.MOD(ROWS), .W(ROW_W)) u_row_cnt (
    .clk     (cnt_clk),
    .rst_n   (cnt_rst_b),
    .en      (col_wrap),
    .clr     (cnt_clr),
    .value_o (cnt_row_o),
    .wrap_o  (row_wrap)
  );

  // ch_wrap already implies an accepted beat on the last channel.
  assign win_evt  = ch_wrap && (cnt_col_o >= COL_W'(KERNEL - 1)) && (cnt_row_o >= ROW_W'(KERNEL - 1));
  assign fill_evt = col_wrap && (cnt_row_o == ROW_W'(KERNEL - 2));

  always_ff @(posedge cnt_clk or negedge cnt_rst_b) begin
    if (!cnt_rst_b) begin
      state            <= IDLE;
      mode_q           <= MODE_SINGLE;
      cnt_fill_done_o  <= 1'b0;
      cnt_win_vld_o    <= 1'b0;
      cnt_line_end_o   <= 1'b0;
      cnt_frame_done_o <= 1'b0;
      cnt_done_o       <= 1'b0;
    end else if (cnt_clr) begin
      state            <= IDLE;
      cnt_fill_done_o  <= 1'b0;
      cnt_win_vld_o    <= 1'b0;
      cnt_line_end_o   <= 1'b0;
      cnt_frame_done_o <= 1'b0;
      cnt_done_o       <= 1'b0;
    end else begin
      cnt_win_vld_o    <= win_evt;
      cnt_line_end_o   <= col_wrap;
      cnt_frame_done_o <= row_wrap;
      case (state)
        IDLE: begin
          if (cnt_en) begin
            mode_q <= cnt_mode_i;
            state  <= FILL;
          end
        end
        FILL: begin
          if (fill_evt) begin
            state           <= STREAM;
            cnt_fill_done_o <= 1'b1;
          end
        end
        STREAM: begin
          if (row_wrap) begin
            cnt_fill_done_o <= 1'b0;
            if (mode_q == MODE_SINGLE) begin
              state      <= DONE;
              cnt_done_o <= 1'b1;
            end else begin
              state <= FILL;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lb_pxl_win_cnt.sv
// Bench for lb_pxl_win_cnt: three parameter sets driven in lock-step, each checked every cycle against a beat-index model.
module tb_lb_pxl_win_cnt;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic mode = 1'b0;

  always #5 clk = ~clk;

  // dut0: defaults; dut1: CHANNELS=2; dut2: 4x4 frame with K=4
  logic [0:0] d0_ch, d1_ch, d2_ch;
  logic [2:0] d0_col, d1_col;
  logic [1:0] d2_col;
  logic [1:0] d0_row, d1_row, d2_row;
  logic d0_fill, d0_win, d0_line, d0_frame, d0_done;
  logic d1_fill, d1_win, d1_line, d1_frame, d1_done;
  logic d2_fill, d2_win, d2_line, d2_frame, d2_done;

  lb_pxl_win_cnt dut0 (
    .cnt_clk(clk), .cnt_rst_b(rst_n), .cnt_en(en), .cnt_clr(clr), .cnt_mode_i(mode),
    .cnt_ch_o(d0_ch), .cnt_col_o(d0_col), .cnt_row_o(d0_row),
    .cnt_fill_done_o(d0_fill), .cnt_win_vld_o(d0_win), .cnt_line_end_o(d0_line),
    .cnt_frame_done_o(d0_frame), .cnt_done_o(d0_done)
  );

  lb_pxl_win_cnt #(.CHANNELS(2)) dut1 (
    .cnt_clk(clk), .cnt_rst_b(rst_n), .cnt_en(en), .cnt_clr(clr), .cnt_mode_i(mode),
    .cnt_ch_o(d1_ch), .cnt_col_o(d1_col), .cnt_row_o(d1_row),
    .cnt_fill_done_o(d1_fill), .cnt_win_vld_o(d1_win), .cnt_line_end_o(d1_line),
    .cnt_frame_done_o(d1_frame), .cnt_done_o(d1_done)
  );

  lb_pxl_win_cnt #(.COLS(4), .ROWS(4), .KERNEL(4)) dut2 (
    .cnt_clk(clk), .cnt_rst_b(rst_n), .cnt_en(en), .cnt_clr(clr), .cnt_mode_i(mode),
    .cnt_ch_o(d2_ch), .cnt_col_o(d2_col), .cnt_row_o(d2_row),
    .cnt_fill_done_o(d2_fill), .cnt_win_vld_o(d2_win), .cnt_line_end_o(d2_line),
    .cnt_frame_done_o(d2_frame), .cnt_done_o(d2_done)
  );

  // flags packed as {fill, win, line, frame, done}
  int         a_ch [3];
  int         a_col[3];
  int         a_row[3];
  logic [4:0] a_fl [3];

  always_comb begin
    a_ch[0] = int'(d0_ch); a_col[0] = int'(d0_col); a_row[0] = int'(d0_row);
    a_ch[1] = int'(d1_ch); a_col[1] = int'(d1_col); a_row[1] = int'(d1_row);
    a_ch[2] = int'(d2_ch); a_col[2] = int'(d2_col); a_row[2] = int'(d2_row);
    a_fl[0] = {d0_fill, d0_win, d0_line, d0_frame, d0_done};
    a_fl[1] = {d1_fill, d1_win, d1_line, d1_frame, d1_done};
    a_fl[2] = {d2_fill, d2_win, d2_line, d2_frame, d2_done};
  end

  typedef struct { int chs; int cols; int rows; int k; } cfg_t;
  // phase: 0 idle, 1 counting, 2 finished; b = index of the next beat within the frame
  typedef struct { int phase; int b; bit mode; bit win; bit line; bit frame; } mdl_t;
  typedef struct { int beat; int col; int row; logic [4:0] fl; } vec_t;

  cfg_t cfgs[3];
  mdl_t mdl[3];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   beats = 0;
  int   n_win[3];
  int   n_line[3];
  int   n_frame[3];

  function automatic mdl_t mstep(cfg_t c, mdl_t s, bit e, bit cl, bit md);
    mdl_t n = s;
    int ch, col, row;
    n.win = 0; n.line = 0; n.frame = 0;
    if (cl) begin
      n.phase = 0;
      n.b = 0;
      return n;
    end
    if (e && s.phase != 2) begin
      ch  = s.b % c.chs;
      col = (s.b / c.chs) % c.cols;
      row = s.b / (c.chs * c.cols);
      n.win   = (ch == c.chs - 1) && (col >= c.k - 1) && (row >= c.k - 1);
      n.line  = (ch == c.chs - 1) && (col == c.cols - 1);
      n.frame = n.line && (row == c.rows - 1);
      if (s.phase == 0) begin
        n.phase = 1;
        n.mode  = md;
      end
      n.b = s.b + 1;
      if (n.frame) begin
        n.b = 0;
        n.phase = n.mode ? 1 : 2;
      end
    end
    return n;
  endfunction

  task automatic check_dut(input int i);
    cfg_t c;
    mdl_t s;
    int ech, ecol, erow;
    logic [4:0] efl;
    c = cfgs[i];
    s = mdl[i];
    ech  = s.b % c.chs;
    ecol = (s.b / c.chs) % c.cols;
    erow = s.b / (c.chs * c.cols);
    efl  = {(s.phase == 1) && (s.b >= c.chs * c.cols * (c.k - 1)), s.win, s.line, s.frame, s.phase == 2};
    n_cmp++;
    if (a_ch[i] != ech || a_col[i] != ecol || a_row[i] != erow || a_fl[i] !== efl) begin
      n_bad++;
      $display("FAIL model_dut%0d cyc=%0d got ch=%0d col=%0d row=%0d flags=%b, want ch=%0d col=%0d row=%0d flags=%b",
               i, cyc, a_ch[i], a_col[i], a_row[i], a_fl[i], ech, ecol, erow, efl);
    end
  endtask

  task automatic expect_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic zero_cnt();
    beats = 0;
    for (int i = 0; i < 3; i++) begin
      n_win[i] = 0; n_line[i] = 0; n_frame[i] = 0;
    end
  endtask

  // Inputs change on the falling edge; outputs are checked on the next falling edge.
  task automatic cycle(input bit e, input bit cl, input bit md);
    en = e; clr = cl; mode = md;
    @(posedge clk);
    for (int i = 0; i < 3; i++) mdl[i] = mstep(cfgs[i], mdl[i], e, cl, md);
    @(negedge clk);
    cyc++;
    if (e && !cl) beats++;
    for (int i = 0; i < 3; i++) begin
      check_dut(i);
      n_win[i]   += int'(a_fl[i][3]);
      n_line[i]  += int'(a_fl[i][2]);
      n_frame[i] += int'(a_fl[i][1]);
    end
  endtask

  task automatic reset_models();
    for (int i = 0; i < 3; i++) mdl[i] = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
  endtask

  vec_t tbl[8];
  int f1, f2, lowfill, gap_pulses, coinc, fill11, fill12;
  bit ph, gap_done;

  initial begin
    cfgs[0] = '{1, 8, 4, 3};
    cfgs[1] = '{2, 8, 4, 3};
    cfgs[2] = '{1, 4, 4, 4};
    reset_models();
    zero_cnt();

    // dut0, mode 0: state after the given number of back-to-back beats
    tbl[0] = '{1,  1, 0, 5'b00000};
    tbl[1] = '{8,  0, 1, 5'b00100};
    tbl[2] = '{16, 0, 2, 5'b10100};
    tbl[3] = '{18, 2, 2, 5'b10000};
    tbl[4] = '{19, 3, 2, 5'b11000};
    tbl[5] = '{24, 0, 3, 5'b11100};
    tbl[6] = '{32, 0, 0, 5'b01111};
    tbl[7] = '{34, 0, 0, 5'b00001};

    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) check_dut(i);
    rst_n = 1'b1;

    // single frame, continuous beats
    for (int t = 0; t < 8; t++) begin
      while (beats < tbl[t].beat) cycle(1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (a_ch[0] != 0 || a_col[0] != tbl[t].col || a_row[0] != tbl[t].row || a_fl[0] !== tbl[t].fl) begin
        n_bad++;
        $display("FAIL table_beat%0d got col=%0d row=%0d flags=%b, want col=%0d row=%0d flags=%b",
                 tbl[t].beat, a_col[0], a_row[0], a_fl[0], tbl[t].col, tbl[t].row, tbl[t].fl);
      end
    end
    expect_int("single_win_count", n_win[0], 12);
    expect_int("single_line_count", n_line[0], 4);
    expect_int("single_frame_count", n_frame[0], 1);

    // continuous mode, two channels
    cycle(1'b0, 1'b1, 1'b0);
    zero_cnt();
    f1 = -1; f2 = -1; lowfill = 0;
    repeat (128) begin
      cycle(1'b1, 1'b0, 1'b1);
      if (a_fl[1][1]) begin
        if (f1 < 0) f1 = beats;
        else f2 = beats;
      end
      if (beats >= 64 && beats <= 127 && !a_fl[1][4]) lowfill++;
    end
    expect_int("ch2_frame_count", n_frame[1], 2);
    expect_int("ch2_first_frame_beat", f1, 64);
    expect_int("ch2_frame_spacing", f2 - f1, 64);
    expect_int("ch2_win_count", n_win[1], 24);
    expect_int("ch2_refill_low_beats", lowfill, 32);

    // alternating stalls with a 5-cycle gap mid-row
    cycle(1'b0, 1'b1, 1'b0);
    zero_cnt();
    gap_pulses = 0; gap_done = 0; ph = 1;
    while (beats < 32) begin
      if (beats == 12 && !gap_done) begin
        repeat (5) begin
          cycle(1'b0, 1'b0, 1'b0);
          gap_pulses += int'(a_fl[0][3]) + int'(a_fl[0][2]) + int'(a_fl[0][1]);
        end
        gap_done = 1;
      end else begin
        cycle(ph, 1'b0, 1'b0);
        ph = !ph;
      end
    end
    expect_int("stall_win_count", n_win[0], 12);
    expect_int("stall_line_count", n_line[0], 4);
    expect_int("stall_frame_count", n_frame[0], 1);
    expect_int("stall_done", int'(a_fl[0][0]), 1);
    expect_int("stall_gap_pulses", gap_pulses, 0);

    // clear coincident with beat 20
    cycle(1'b0, 1'b1, 1'b0);
    repeat (19) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    expect_int("clr_col", a_col[0], 0);
    expect_int("clr_row", a_row[0], 0);
    expect_int("clr_flags", int'(a_fl[0]), 0);
    zero_cnt();
    repeat (32) cycle(1'b1, 1'b0, 1'b0);
    expect_int("after_clr_win_count", n_win[0], 12);
    expect_int("after_clr_done", int'(a_fl[0][0]), 1);

    // asynchronous reset in the middle of STREAM
    cycle(1'b0, 1'b1, 1'b0);
    repeat (20) cycle(1'b1, 1'b0, 1'b1);
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    reset_models();
    for (int i = 0; i < 3; i++) check_dut(i);
    expect_int("areset_fill", int'(a_fl[0][4]), 0);
    expect_int("areset_col", a_col[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    zero_cnt();
    repeat (32) cycle(1'b1, 1'b0, 1'b1);
    expect_int("post_reset_win_count", n_win[0], 12);
    expect_int("post_reset_line_count", n_line[0], 4);
    expect_int("post_reset_frame_count", n_frame[0], 1);
    expect_int("post_reset_not_done", int'(a_fl[0][0]), 0);

    // K = ROWS = COLS = 4
    cycle(1'b0, 1'b1, 1'b0);
    zero_cnt();
    coinc = 0; fill11 = -1; fill12 = -1;
    for (int t = 1; t <= 16; t++) begin
      cycle(1'b1, 1'b0, 1'b0);
      if (t == 11) fill11 = int'(a_fl[2][4]);
      if (t == 12) fill12 = int'(a_fl[2][4]);
      if (a_fl[2][3] && a_fl[2][1]) coinc++;
    end
    expect_int("k4_fill_before", fill11, 0);
    expect_int("k4_fill_after12", fill12, 1);
    expect_int("k4_win_count", n_win[2], 1);
    expect_int("k4_win_with_frame", coinc, 1);

    // randomized traffic against the model
    cycle(1'b0, 1'b1, 1'b0);
    repeat (3000) begin
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
